serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller that computes `minuend - subtrahend - borrow_in` over WIDTH clock cycles. It time-shares a single `full_subtractor` cell, feeding it one bit per cycle LSB-first and carrying the borrow through a register. It sits between a requester issuing `start` with operands and the one-bit subtractor datapath, and provides a start/busy/done handshake and a stable result register.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor_ctrl.sv | 143 ++++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_subtractor_pkg;

    // Controller states; the 2-bit encoding is also exported as a debug output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Operand and result width used when the top is not overridden.
    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: minuend - subtrahend - borrow_in over
// WIDTH cycles, LSB first, through a single full_subtractor cell.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the signed overflow output.
//
// Handshake: start is sampled only in IDLE or DONE; busy is high for the WIDTH
// bit cycles; done pulses for one cycle when diff/borrow_out are updated.
// diff, borrow_out (and overflow) only change on entry to DONE.
module serial_subtractor_ctrl
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            work_q   <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state logic: operand capture, per-bit shift, and result commit.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d      = minuend;
                    b_d      = subtrahend;
                    borrow_d = borrow_in;
                    cnt_d    = '0;
                    work_d   = '0;
                    state_d  = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
                work_d   = {cell_d, work_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    diff_d  = work_d;
                    bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    // Borrow into the MSB differs from borrow out of it.
                    ovf_d   = borrow_q ^ cell_bout;
`endif
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign dbg_state  = state_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed testbench for serial_subtractor_ctrl (WIDTH=8).
module tb_serial_subtractor_ctrl;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  logic [1:0]   dbg_state;

  int checks;
  int failures;
  logic [W-1:0] last_diff;
  logic [W:0]   exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow   (overflow),
`endif
    .dbg_state  (dbg_state)
  );

`ifndef SERIAL_SUB_OVERFLOW_EN
  assign overflow = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present operands with start, release #1 after the sampling edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    minuend    = a;
    subtrahend = b;
    borrow_in  = bin;
    start      = 1'b1;
    exp_q.push_back({1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("done_fall", {31'd0, done}, 32'd0);
  endtask

  // wait for done, optionally disturbing inputs mid-operation; returns at the negedge of the DONE cycle
  task automatic wait_done(input string tag, input logic exp_ovf, input bit disturb);
    int edges;
    int busy_cnt;
    bit got;
    logic [W:0] exp;
    edges = 1;
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      check({tag, "_diff_held"}, {24'd0, diff}, {24'd0, last_diff});
      if (disturb && busy_cnt == 3) begin
        start      = 1'b1;
        minuend    = 8'hAA;
        subtrahend = 8'h55;
        borrow_in  = 1'b1;
      end
      if (disturb && busy_cnt == 5) start = 1'b0;
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    exp = exp_q.pop_front();
    check({tag, "_latency"}, edges, 32'd9);
    check({tag, "_busy_cycles"}, busy_cnt, 32'd8);
    check({tag, "_diff"}, {24'd0, diff}, {24'd0, exp[W-1:0]});
    check({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, exp[W]});
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) check({tag, "_ovf"}, 32'd0, 32'd1);
`endif
    last_diff = exp[W-1:0];
  endtask

  task automatic check_idle(input string tag, input logic [W-1:0] exp_diff);
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, IDLE});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_diff});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_diff = '0;
    rst_n = 1'b0;
    start = 1'b0;
    minuend = '0;
    subtrahend = '0;
    borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset", 8'h00);
    check("reset_borrow", {31'd0, borrow_out}, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);

    // basic subtraction and done pulse width
    start_op(8'h5A, 8'h23, 1'b0);
    wait_done("sub_5a_23", 1'b0, 1'b0);
    check("sub_5a_23_const", {24'd0, diff}, 32'h37);
    @(negedge clk);
    check_idle("after_done", 8'h37);

    start_op(8'h10, 8'h20, 1'b0);
    wait_done("sub_10_20", 1'b0, 1'b0);
    check("sub_10_20_const", {23'd0, borrow_out, diff}, 32'h1F0);
    @(negedge clk);

    start_op(8'h00, 8'h00, 1'b1);
    wait_done("sub_00_00_b", 1'b0, 1'b0);
    check("sub_00_00_b_const", {23'd0, borrow_out, diff}, 32'h1FF);
    @(negedge clk);

    start_op(8'h80, 8'h01, 1'b0);
    wait_done("sub_80_01", 1'b1, 1'b0);
    @(negedge clk);

    start_op(8'h05, 8'h03, 1'b0);
    wait_done("sub_05_03", 1'b0, 1'b0);
    @(negedge clk);

    // start and operands disturbed mid-operation
    start_op(8'h33, 8'h11, 1'b0);
    wait_done("disturb", 1'b0, 1'b1);
    check("disturb_const", {24'd0, diff}, 32'h22);
    @(negedge clk);
    check_idle("after_disturb", 8'h22);

    // back-to-back: start held in the DONE cycle
    start_op(8'h5A, 8'h23, 1'b0);
    wait_done("b2b_first", 1'b0, 1'b0);
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done("b2b_second", 1'b0, 1'b0);
    check("b2b_const", {24'd0, diff}, 32'hFE);
    @(negedge clk);

    // reset in bit cycle 4 with a pending borrow
    start_op(8'h00, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    last_diff = '0;
    @(negedge clk);
    check_idle("mid_reset", 8'h00);
    check("mid_reset_borrow", {31'd0, borrow_out}, 32'd0);
    check("mid_reset_ovf", {31'd0, overflow}, 32'd0);
    repeat (12) begin
      @(negedge clk);
      check("mid_reset_no_done", {31'd0, done}, 32'd0);
    end
    start_op(8'h5A, 8'h23, 1'b0);
    wait_done("post_reset", 1'b0, 1'b0);
    check("post_reset_const", {23'd0, borrow_out, diff}, 32'h037);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
